alu_issue: RTL

- Sequential operand-supply and writeback stage sitting on the far side of the combinational RV64 ALU.
- Accepts one R-type (opcode 0110011) or I-type (opcode 0010011) instruction at a time over a valid/ready handshake.
- Reads rs1/rs2 from an internal 32x64 register file and builds a sanitised instruction word plus the in1/in2 operands for the ALU.
- Captures the ALU result and writes it back to rd.

---
 rtl/alu_issue_pkg.sv | 39 +++
 rtl/alu_issue_reg_file.sv | 36 +++
 rtl/alu_issue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the alu_issue operand-supply / writeback stage.
// Optional feature macro: ALU_ISSUE_RETIRE_CNT_EN (retired-instruction counter).
package alu_issue_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = $clog2(NREGS);
    localparam int unsigned IW     = 32;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

    // RV base instruction layout (R-type field names; I-type imm = {funct7, rs2})
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_instr_t;

    // I-type words get a clean funct7 so the ALU never sees ADDI as SUB; SRAI keeps its alt bit
    function automatic rv_instr_t sanitise(input rv_instr_t ins);
        rv_instr_t s;
        s = ins;
        if (ins.opcode == OP_IMM) begin
            s.funct7 = (ins.funct3 == F3_SR && ins.funct7[5]) ? F7_ALT : F7_ZERO;
        end
        return s;
    endfunction

endpackage

// File: rtl/alu_issue_reg_file.sv
// 32x64 architectural register file: 2 read ports, 1 write port, 1 debug read port.
// Synchronous write and synchronous clear; x0 always reads zero.
module reg_file
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [XLEN-1:0]   rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] regs [NREGS];

    // Write port; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-supply and writeback stage wrapped around an external combinational RV64 ALU.
// IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles, done fixed at accept+3.
// Optional feature macro: ALU_ISSUE_RETIRE_CNT_EN enables the retire_count register.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [IW-1:0]     instruction,
    output logic [IW-1:0]     alu_instruction,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    input  logic [XLEN-1:0]   alu_out,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              done,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic [31:0]       retire_count
);

    state_e          state;
    rv_instr_t       ins_q;
    logic            illegal_q;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            is_reg;
    logic            is_legal;
    logic            is_shift;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] shamt_zext;

    // Decode of the latched instruction
    assign is_reg     = (ins_q.opcode == OP_REG);
    assign is_legal   = is_reg || (ins_q.opcode == OP_IMM);
    assign is_shift   = (ins_q.funct3 == F3_SLL) || (ins_q.funct3 == F3_SR);
    assign imm_sext   = {{(XLEN-12){ins_q.funct7[6]}}, ins_q.funct7, ins_q.rs2};
    assign shamt_zext = {{(XLEN-6){1'b0}}, ins_q.funct7[0], ins_q.rs2};

    reg_file u_reg_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (ins_q.rs1),
        .rs1_data (rs1_data),
        .rs2_addr (ins_q.rs2),
        .rs2_data (rs2_data),
        .we       (wb_en),
        .wa       (wb_addr),
        .wd       (wb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Sequencer with registered handshake, operand and writeback outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ins_q           <= '0;
            illegal_q       <= 1'b0;
            instr_ready     <= 1'b1;
            alu_instruction <= '0;
            alu_in1         <= '0;
            alu_in2         <= '0;
            wb_en           <= 1'b0;
            wb_addr         <= '0;
            wb_data         <= '0;
            done            <= 1'b0;
            illegal         <= 1'b0;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
            retire_count    <= '0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        ins_q       <= instruction;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    // Illegal words keep the previous operands and still take the EXEC slot
                    illegal_q <= !is_legal;
                    if (is_legal) begin
                        alu_in1         <= rs1_data;
                        alu_instruction <= sanitise(ins_q);
                        if (is_reg) begin
                            alu_in2 <= rs2_data;
                        end else if (is_shift) begin
                            alu_in2 <= shamt_zext;
                        end else begin
                            alu_in2 <= imm_sext;
                        end
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    done    <= 1'b1;
                    illegal <= illegal_q;
                    if (!illegal_q && ins_q.rd != '0) begin
                        wb_en   <= 1'b1;
                        wb_addr <= ins_q.rd;
                        wb_data <= alu_out;
                    end
                    state <= WB;
                end
                WB: begin
`ifdef ALU_ISSUE_RETIRE_CNT_EN
                    retire_count <= retire_count + 32'd1;
`endif
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifndef ALU_ISSUE_RETIRE_CNT_EN
    assign retire_count = '0;
`endif

endmodule
